// File: rtl/sha_pkg.sv
// Shared types and helpers for the SHA-3 stream digest path.
package sha_pkg;

    localparam int MAX_DIGEST_BITS = 512;

    typedef enum logic [1:0] {
        SHA224 = 2'd0,
        SHA256 = 2'd1,
        SHA384 = 2'd2,
        SHA512 = 2'd3
    } sha_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_HOLD
    } coll_state_t;

    function automatic int digest_words(input sha_mode_t mode, input int dw);
        int bits;
        case (mode)
            SHA224:  bits = 224;
            SHA256:  bits = 256;
            SHA384:  bits = 384;
            default: bits = 512;
        endcase
        return bits / dw;
    endfunction

endpackage

// File: rtl/sha_digest_collector.sv
// Assembles streamed digest words into one register and holds it
// under a valid/ready handshake, flagging beat-count mismatches.
module sha_digest_collector #(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_DIGEST_BITS = sha_pkg::MAX_DIGEST_BITS
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       S_TVALID,
    output logic                       S_TREADY,
    input  logic [DATA_WIDTH-1:0]      S_TDATA,
    input  logic                       S_TLAST,
    input  logic [1:0]                 S_TUSER,
    output logic [MAX_DIGEST_BITS-1:0] digest_o,
    output logic [1:0]                 digest_len_o,
    output logic                       digest_valid_o,
    input  logic                       digest_ready_i,
    output logic                       err_o,
    output logic                       busy_o
);
    import sha_pkg::*;

    localparam int WI_W = 5;

    coll_state_t                state_q, state_d;
    logic [WI_W-1:0]            wi_q, wi_d;
    logic [MAX_DIGEST_BITS-1:0] dig_q, dig_d;
    sha_mode_t                  len_q, len_d;
    logic                       err_q, err_d;
    logic                       beat;
    logic [WI_W-1:0]            last_idx;

    assign S_TREADY       = (state_q != ST_HOLD);
    assign beat           = S_TVALID && S_TREADY;
    assign last_idx       = WI_W'(digest_words(len_q, DATA_WIDTH) - 1);
    assign digest_o       = dig_q;
    assign digest_len_o   = len_q;
    assign digest_valid_o = (state_q == ST_HOLD);
    assign err_o          = err_q;
    assign busy_o         = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        wi_d    = wi_q;
        dig_d   = dig_q;
        len_d   = len_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    dig_d                 = '0;
                    dig_d[DATA_WIDTH-1:0] = S_TDATA;
                    len_d                 = sha_mode_t'(S_TUSER);
                    err_d                 = 1'b0;
                    wi_d                  = WI_W'(1);
                    // Every variant needs well over one word, so a lone beat is short.
                    if (S_TLAST) begin
                        state_d = ST_HOLD;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (beat) begin
                    dig_d[wi_q*DATA_WIDTH +: DATA_WIDTH] = S_TDATA;
                    if (wi_q == last_idx) begin
                        state_d = S_TLAST ? ST_HOLD : ST_DRAIN;
                        err_d   = !S_TLAST;
                    end else begin
                        wi_d = wi_q + 1'b1;
                        if (S_TLAST) begin
                            state_d = ST_HOLD;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && S_TLAST) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (digest_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            wi_q    <= '0;
            dig_q   <= '0;
            len_q   <= SHA224;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wi_q    <= wi_d;
            dig_q   <= dig_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sha_digest_collector.sv
// Randomized self-checking bench for sha_digest_collector against a
// frame-level reference model.
module tb_sha_digest_collector;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic         S_TVALID;
    logic         S_TREADY;
    logic [15:0]  S_TDATA;
    logic         S_TLAST;
    logic [1:0]   S_TUSER;
    logic [511:0] digest_o;
    logic [1:0]   digest_len_o;
    logic         digest_valid_o;
    logic         digest_ready_i;
    logic         err_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    logic [15:0]  words [0:63];
    logic [511:0] exp_dig;
    logic         exp_err;

    sha_digest_collector #(
        .DATA_WIDTH      (16),
        .MAX_DIGEST_BITS (512)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .S_TVALID       (S_TVALID),
        .S_TREADY       (S_TREADY),
        .S_TDATA        (S_TDATA),
        .S_TLAST        (S_TLAST),
        .S_TUSER        (S_TUSER),
        .digest_o       (digest_o),
        .digest_len_o   (digest_len_o),
        .digest_valid_o (digest_valid_o),
        .digest_ready_i (digest_ready_i),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nwords(input int mode);
        case (mode)
            0:       return 14;
            1:       return 16;
            2:       return 24;
            default: return 32;
        endcase
    endfunction

    // Frame model: the first min(beats, N) words land in order, rest is zero.
    task automatic model(input int mode, input int nb);
        exp_dig = '0;
        for (int k = 0; k < nb && k < nwords(mode); k++)
            exp_dig[k*16 +: 16] = words[k];
        exp_err = (nb != nwords(mode));
    endtask

    task automatic check_hold(input int mode);
        chk("valid", digest_valid_o, 1);
        chk("tready_hold", S_TREADY, 0);
        chk("busy_hold", busy_o, 0);
        chk("err", err_o, exp_err);
        chk("len", digest_len_o, mode);
        chk("digest", digest_o, exp_dig);
    endtask

    task automatic send_frame(input int mode, input int nb, input int duty,
                              input bit fixed);
        int b = 0;
        int budget = 0;
        for (int k = 0; k < nb; k++)
            words[k] = fixed ? 16'(16'h0100 + k) : 16'($urandom);
        while (b < nb) begin
            @(negedge ACLK);
            if (b > 0) chk("busy", busy_o, 1);
            S_TVALID = ($urandom_range(0, 99) < duty);
            S_TDATA  = words[b];
            S_TLAST  = (b == nb - 1);
            S_TUSER  = (b == 0) ? mode[1:0] : 2'($urandom);
            if (S_TVALID) begin
                chk("tready", S_TREADY, 1);
                b++;
            end
            budget++;
            if (budget > 2000) begin
                chk("frame_timeout", 0, 1);
                break;
            end
        end
        @(negedge ACLK);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        model(mode, nb);
        check_hold(mode);
    endtask

    task automatic release_hold();
        digest_ready_i = 1'b1;
        @(negedge ACLK);
        digest_ready_i = 1'b0;
        chk("valid_fall", digest_valid_o, 0);
        chk("tready_idle", S_TREADY, 1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_tready"}, S_TREADY, 1);
        chk({tag, "_valid"}, digest_valid_o, 0);
        chk({tag, "_digest"}, digest_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_len"}, digest_len_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        ARESET         = 1'b1;
        S_TVALID       = 1'b0;
        S_TDATA        = '0;
        S_TLAST        = 1'b0;
        S_TUSER        = '0;
        digest_ready_i = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        check_cleared("rst");

        send_frame(1, 16, 100, 1'b1);
        chk("w0", digest_o[15:0], 16'h0100);
        chk("w15", digest_o[255:240], 16'h010F);
        chk("upper256", digest_o[511:256], 0);
        release_hold();

        send_frame(3, 32, 50, 1'b0);
        release_hold();

        send_frame(0, 10, 70, 1'b0);
        chk("short_zero", digest_o[223:160], 0);
        release_hold();

        send_frame(2, 26, 100, 1'b0);
        chk("drain_zero", digest_o[511:384], 0);
        repeat (20) begin
            @(negedge ACLK);
            S_TVALID = 1'b1;
            S_TDATA  = 16'($urandom);
            S_TLAST  = 1'($urandom);
            chk("stall_tready", S_TREADY, 0);
            chk("stall_valid", digest_valid_o, 1);
            chk("stall_digest", digest_o, exp_dig);
        end
        @(negedge ACLK);
        digest_ready_i = 1'b1;
        S_TVALID       = 1'b1;
        S_TLAST        = 1'b0;
        S_TDATA        = 16'hBEEF;
        S_TUSER        = 2'd1;
        @(negedge ACLK);
        digest_ready_i = 1'b0;
        chk("hs_valid", digest_valid_o, 0);
        chk("hs_nobeat", busy_o, 0);
        chk("hs_tready", S_TREADY, 1);
        @(negedge ACLK);
        S_TVALID = 1'b0;
        chk("post_hs_beat", busy_o, 1);
        chk("post_hs_w0", digest_o[15:0], 16'hBEEF);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check_cleared("rst_mid");

        for (int k = 0; k < 8; k++) begin
            @(negedge ACLK);
            S_TVALID = 1'b1;
            S_TDATA  = 16'($urandom);
            S_TUSER  = 2'd3;
            S_TLAST  = 1'b0;
        end
        @(negedge ACLK);
        chk("partial_busy", busy_o, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET   = 1'b0;
        S_TVALID = 1'b0;
        check_cleared("rst_frame");
        send_frame(1, 16, 60, 1'b0);
        release_hold();

        repeat (8) begin
            int mode;
            int nb;
            mode = $urandom_range(0, 3);
            nb   = $urandom_range(1, 36);
            send_frame(mode, nb, $urandom_range(30, 100), 1'b0);
            release_hold();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
